// File: rtl/float_pkg.sv
// float_pkg: shared types for the multiplier result buffer.
package float_pkg;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
  typedef logic [2:0] flag_t;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;
  function automatic logic is_exception(input flag_t f);
    return f[FLAG_OVF] | f[FLAG_UNF];
  endfunction
endpackage

// File: rtl/float_sticky_status.sv
// float_sticky_status: sticky exception flags and saturating exception counter.
module float_sticky_status
  import float_pkg::*;
#(
  parameter int COUNT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  flag_t                 flags,
  input  logic                  flags_clear,
  output flag_t                 flags_sticky,
  output logic [COUNT_SIZE-1:0] exc_count
);
  flag_t                 sticky_base;
  logic [COUNT_SIZE-1:0] count_base;
  logic                  bump;
  // A clear only wipes history; a beat accepted in the same cycle still lands on top of it.
  always_comb begin
    sticky_base = flags_clear ? '0 : flags_sticky;
    count_base  = flags_clear ? '0 : exc_count;
    bump        = accept && is_exception(flags) && !(&count_base);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_sticky <= '0;
      exc_count    <= '0;
    end else begin
      flags_sticky <= accept ? (sticky_base | flags) : sticky_base;
      exc_count    <= bump ? count_base + 1'b1 : count_base;
    end
  end
endmodule

// File: rtl/float_result_buffer.sv
// float_result_buffer: two-entry skid buffer for multiplier products with status tracking.
module float_result_buffer
  import float_pkg::*;
#(
  parameter int FLOAT_SIZE = 32,
  parameter int COUNT_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] in_float,
  input  logic                  in_overflow,
  input  logic                  in_underflow,
  input  logic                  in_inexact,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out_float,
  output flag_t                 out_flags,
  output flag_t                 flags_sticky,
  input  logic                  flags_clear,
  output logic [COUNT_SIZE-1:0] exc_count
);
  buf_state_t            state;
  logic [FLOAT_SIZE-1:0] skid_float;
  flag_t                 skid_flags;
  flag_t                 in_flags;
  logic                  accept;
  logic                  rel;
  always_comb begin
    in_flags = {in_overflow, in_underflow, in_inexact};
    accept   = in_valid & in_ready;
    rel      = out_valid & out_ready;
  end
  // in_ready and out_valid are state-decoded registers, so no ready path reaches upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_float  <= '0;
      out_flags  <= '0;
      skid_float <= '0;
      skid_flags <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_float <= in_float;
          out_flags <= in_flags;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: if (accept && rel) begin
          out_float <= in_float;
          out_flags <= in_flags;
        end else if (accept) begin
          skid_float <= in_float;
          skid_flags <= in_flags;
          in_ready   <= 1'b0;
          state      <= FULL;
        end else if (rel) begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
        FULL: if (rel) begin
          out_float <= skid_float;
          out_flags <= skid_flags;
          in_ready  <= 1'b1;
          state     <= ONE;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
  float_sticky_status #(.COUNT_SIZE(COUNT_SIZE)) u_status (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .flags        (in_flags),
    .flags_clear  (flags_clear),
    .flags_sticky (flags_sticky),
    .exc_count    (exc_count)
  );
endmodule

// File: tb/tb_float_result_buffer.sv
// tb_float_result_buffer: scoreboard bench for float_result_buffer (COUNT_SIZE=2).
module tb_float_result_buffer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_float = '0;
  logic        in_overflow = 0;
  logic        in_underflow = 0;
  logic        in_inexact = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_float;
  logic [2:0]  out_flags;
  logic [2:0]  flags_sticky;
  logic        flags_clear = 0;
  logic [1:0]  exc_count;
  int total = 0;
  int passed = 0;
  logic [34:0] sb[$];
  float_result_buffer #(.FLOAT_SIZE(32), .COUNT_SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_float(in_float), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .in_inexact(in_inexact), .out_valid(out_valid), .out_ready(out_ready),
    .out_float(out_float), .out_flags(out_flags), .flags_sticky(flags_sticky),
    .flags_clear(flags_clear), .exc_count(exc_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // Monitor: a head seen valid+ready before the edge is released on that edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underrun", {out_float, out_flags}, 64'hdead);
      else chk("sb_beat", {out_float, out_flags}, sb.pop_front());
    end
  end
  task automatic send(input logic [31:0] f, input logic [2:0] fl);
    bit done = 0;
    in_valid = 1;
    in_float = f;
    {in_overflow, in_underflow, in_inexact} = fl;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({f, fl});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 0;
    {in_overflow, in_underflow, in_inexact} = 3'b000;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_clear();
    flags_clear = 1;
    cyc(1);
    flags_clear = 0;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_float", out_float, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", flags_sticky, 0);
    chk("rst_exc", exc_count, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(1);
    send(32'h40000000, 3'b000);
    chk("t1_valid", out_valid, 1);
    chk("t1_float", out_float, 32'h40000000);
    chk("t1_flags", out_flags, 0);
    chk("t1_sticky", flags_sticky, 0);
    cyc(2);
    out_ready = 0;
    send(32'h3F800000, 3'b000);
    send(32'h40400000, 3'b000);
    chk("t2_full_ready", in_ready, 0);
    chk("t2_head_a", out_float, 32'h3F800000);
    cyc(2);
    chk("t2_hold_a", out_float, 32'h3F800000);
    chk("t2_hold_valid", out_valid, 1);
    out_ready = 1;
    cyc(1);
    chk("t2_ready_back", in_ready, 1);
    chk("t2_head_b", out_float, 32'h40400000);
    cyc(2);
    chk("t2_drained", out_valid, 0);
    send(32'h3F000000, 3'b001);
    send(32'hBF000000, 3'b100);
    chk("t3_sticky", flags_sticky, 3'b101);
    chk("t3_exc", exc_count, 1);
    pulse_clear();
    chk("t3_clr_sticky", flags_sticky, 0);
    chk("t3_clr_exc", exc_count, 0);
    flags_clear = 1;
    send(32'h00000001, 3'b010);
    flags_clear = 0;
    chk("t4_sticky", flags_sticky, 3'b010);
    chk("t4_exc", exc_count, 1);
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      send(32'h7F800000, 3'b100);
      chk($sformatf("t5_exc_%0d", i), exc_count, exp_cnt[i]);
    end
    cyc(3);
    out_ready = 0;
    send(32'h11111111, 3'b001);
    send(32'h22222222, 3'b010);
    chk("t6_full", in_ready, 0);
    #3;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_sticky", flags_sticky, 0);
    chk("t6_rst_exc", exc_count, 0);
    sb.delete();
    cyc(1);
    rst_n = 1;
    out_ready = 1;
    cyc(1);
    send(32'h12345678, 3'b011);
    chk("t7_float", out_float, 32'h12345678);
    chk("t7_sticky", flags_sticky, 3'b011);
    chk("t7_exc", exc_count, 1);
    cyc(3);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/float_result_buffer.md
Name: float_result_buffer

Overview:
- Registered output stage directly downstream of float_multiplier.
- Captures each product {sign, exponent, mantissa} with its overflow, underflow and inexact flags through a valid/ready handshake.
- Buffers results in a 2-entry skid buffer, so in_ready is a register output and carries no combinational path from out_ready.
- Keeps IEEE-style sticky exception flags and a saturating exception counter for the consumer or a status register.

Parameters:
- FLOAT_SIZE, 32, bit-length of the float payload (matches multiplier FLOAT_SIZE).
- COUNT_SIZE, 8, width of the exception counter.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  buffer can accept; registered.
- in_float  input  FLOAT_SIZE  product from float_multiplier out.
- in_overflow  input  1  multiplier overflow.
- in_underflow  input  1  multiplier underflow.
- in_inexact  input  1  multiplier inexact.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_float  output  FLOAT_SIZE  head payload.
- out_flags  output  3  head flags {overflow, underflow, inexact}.
- flags_sticky  output  3  OR of flags over all accepted beats since reset/clear.
- flags_clear  input  1  synchronous clear of flags_sticky and exc_count.
- exc_count  output  COUNT_SIZE  count of accepted beats with overflow|underflow, saturating.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, out_float=0, out_flags=0, flags_sticky=0, exc_count=0, state EMPTY.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Storage: head register (drives outputs) and skid register.
- State EMPTY: accept -> load head, go ONE.
- State ONE:
  - accept & release -> load head with input, stay ONE.
  - accept only -> load skid, go FULL.
  - release only -> go EMPTY.
- State FULL: in_ready=0. Release -> move skid to head, go ONE. Input is ignored while in_ready=0.
- Output registers: out_valid=1 in ONE and FULL; in_ready=0 only in FULL. Both are register outputs.
- Latency: an accepted beat appears on out_* the next cycle when the buffer was EMPTY, or ONE with a release. Throughput is 1 beat/cycle when out_ready is held high.
- Ordering: strict FIFO; payload and flags are never modified (no saturation or rounding here).
- Holding: while out_valid=1 and out_ready=0, out_float and out_flags hold stable.
- Sticky flags: on accept, flags_sticky |= {in_overflow, in_underflow, in_inexact}.
- exc_count: on accept with overflow|underflow, exc_count increments. It saturates at all-ones and never wraps.
- flags_clear: zeroes flags_sticky and exc_count. The buffer contents are untouched.
- Clear and accept in the same cycle: the new beat wins. flags_sticky becomes that beat's flags, and exc_count becomes 1 if that beat has overflow|underflow, else 0.
- Flag inputs are sampled only on accept; values on non-accepted cycles are ignored.
- Reset mid-operation: buffered entries are discarded and all outputs return to reset values asynchronously. The first accept after deassertion behaves as from EMPTY.

Decomposition:
- Package float_pkg:
  - typedef flag vector, 3 bits {overflow, underflow, inexact}, with named index constants.
  - typedef buffer state enum {EMPTY, ONE, FULL}.
- One sub-module: float_sticky_status, holding flags_sticky and the saturating exc_count, driven by accept, the flag vector and flags_clear.
- The skid buffer and state machine stay in the top module.

Test Plan:
- Reset, then one beat in_float=32'h40000000 with flags 000 and out_ready=1 -> the next cycle out_valid=1, out_float=32'h40000000, out_flags=000; flags_sticky=000.
- Hold out_ready=0 and send beats A=32'h3F800000, then B=32'h40400000 -> in_ready=0 after B is accepted, A held on out_float. Raise out_ready -> A then B on consecutive cycles, in_ready returns to 1.
- Send beats with flags 001, then 100 -> flags_sticky=101, exc_count=1. Pulse flags_clear alone -> both read 0 the next cycle.
- flags_clear asserted in the same cycle as an accepted beat with flags 010 -> flags_sticky=010, exc_count=1.
- COUNT_SIZE=2, send 5 beats with overflow=1 -> exc_count reads 1, 2, 3, 3, 3 (saturates, no wrap).
- Buffer FULL, assert rst_n=0 mid-cycle -> out_valid=0, in_ready=1, flags_sticky=0 immediately, without waiting for a clock edge.
